// File: rtl/task_generator.sv
// Pseudo-random (priority, duration) task source with valid/ready output, count and gap control.
// Optional per-priority transfer histogram when TASK_GEN_PRIO_HIST_EN is defined.
module task_generator #(
  parameter int DUR_W = 8,
  parameter int PRIO_W = 3,
  parameter int CNT_W = 16,
  parameter logic [15:0] SEED_DFLT = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [7:0]        cfg_gap,
  input  logic [15:0]       cfg_seed,
  input  logic [DUR_W-1:0]  cfg_dur_mask,
  output logic              task_valid,
  input  logic              task_ready,
  output logic [PRIO_W-1:0] task_priority,
  output logic [DUR_W-1:0]  task_duration,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_count
`ifdef TASK_GEN_PRIO_HIST_EN
  ,
  output logic [4*CNT_W-1:0] prio_hist
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, DONE} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t             state_reg, state_next;
  logic [15:0]        lfsr_reg;
  logic [7:0]         gap_reg;
  logic [CNT_W-1:0]   issued_reg;
  logic [CNT_W-1:0]   cfg_count_reg;
  logic [7:0]         cfg_gap_reg;
  logic [DUR_W-1:0]   mask_reg;

  logic               transfer;
  logic               last_task;
  logic [DUR_W-1:0]   dur_raw;
  logic [15:0]        lfsr_step;

  assign transfer  = (state_reg == ISSUE) && task_ready;
  assign last_task = (cfg_count_reg != '0) && (CNT_W'(issued_reg + 1'b1) == cfg_count_reg);
  assign lfsr_step = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
  assign dur_raw   = DUR_W'(lfsr_reg[15:8]) & mask_reg;

  // Payload is forced to zero outside ISSUE so idle outputs read as 0.
  assign task_valid    = (state_reg == ISSUE);
  assign task_priority = task_valid ? PRIO_W'(lfsr_reg[1:0]) : '0;
  assign task_duration = !task_valid ? '0 :
                         (&dur_raw)  ? dur_raw : dur_raw + DUR_W'(1);
  assign busy          = (state_reg == LOAD) || (state_reg == ISSUE) || (state_reg == GAP);
  assign done          = (state_reg == DONE);
  assign issued_count  = issued_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD:       state_next = ISSUE;
      ISSUE: begin
        if (transfer) begin
          if (last_task || stop)      state_next = DONE;
          else if (cfg_gap_reg != '0) state_next = GAP;
        end
      end
      GAP: begin
        if (stop)              state_next = DONE;
        else if (gap_reg <= 1) state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg      <= SEED_DFLT;
      gap_reg       <= '0;
      issued_reg    <= '0;
      cfg_count_reg <= '0;
      cfg_gap_reg   <= '0;
      mask_reg      <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          lfsr_reg      <= (cfg_seed == 16'h0000) ? SEED_DFLT : cfg_seed;
          issued_reg    <= '0;
          cfg_count_reg <= cfg_count;
          cfg_gap_reg   <= cfg_gap;
          mask_reg      <= cfg_dur_mask;
        end
        ISSUE: begin
          if (transfer) begin
            issued_reg <= issued_reg + 1'b1;
            lfsr_reg   <= lfsr_step;
            gap_reg    <= cfg_gap_reg;
          end
        end
        GAP:     gap_reg <= gap_reg - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TASK_GEN_PRIO_HIST_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hist
      logic [CNT_W-1:0] hist_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          hist_reg <= '0;
        else if (state_reg == LOAD)
          hist_reg <= '0;
        else if (transfer && (lfsr_reg[1:0] == 2'(gi)))
          hist_reg <= hist_reg + 1'b1;
      end
      assign prio_hist[gi*CNT_W +: CNT_W] = hist_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_task_generator.sv
// Directed bench for task_generator: single-task vector table plus stream, gap, stall/stop
// and mid-run reset sequences.
module tb_task_generator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_count = '0;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] cfg_seed = '0;
  logic [7:0]  cfg_dur_mask = '0;
  logic        task_valid;
  logic        task_ready = 1'b0;
  logic [2:0]  task_priority;
  logic [7:0]  task_duration;
  logic        busy;
  logic        done;
  logic [15:0] issued_count;
`ifdef TASK_GEN_PRIO_HIST_EN
  logic [63:0] prio_hist;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task_generator dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .cfg_count(cfg_count),
    .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed),
    .cfg_dur_mask(cfg_dur_mask),
    .task_valid(task_valid),
    .task_ready(task_ready),
    .task_priority(task_priority),
    .task_duration(task_duration),
    .busy(busy),
    .done(done),
    .issued_count(issued_count)
`ifdef TASK_GEN_PRIO_HIST_EN
    ,
    .prio_hist(prio_hist)
`endif
  );

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  mask;
    logic [2:0]  prio;
    logic [7:0]  dur;
  } vec_t;

  vec_t       vecs[7];
  logic [2:0] s_prio[8];
  logic [7:0] s_dur[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge where the DUT sits in LOAD.
  task automatic start_run(input logic [15:0] seed, input logic [7:0] mask,
                           input logic [15:0] count, input logic [7:0] gap);
    cfg_seed = seed;
    cfg_dur_mask = mask;
    cfg_count = count;
    cfg_gap = gap;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hACE1, 8'hFF, 3'd1, 8'hAD};
    vecs[1] = '{16'h0000, 8'hFF, 3'd1, 8'hAD};
    vecs[2] = '{16'hACE1, 8'h00, 3'd1, 8'h01};
    vecs[3] = '{16'hFF00, 8'hFF, 3'd0, 8'hFF};
    vecs[4] = '{16'hACE1, 8'h0F, 3'd1, 8'h0D};
    vecs[5] = '{16'h1234, 8'hF0, 3'd0, 8'h11};
    vecs[6] = '{16'h00FE, 8'hFF, 3'd2, 8'h01};
    // Galois stream from ACE1: ACE1 E270 7138 389C 1C4E 0E27 B313 ED89
    s_prio = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd1};
    s_dur  = '{8'hAD, 8'hE3, 8'h72, 8'h39, 8'h1D, 8'h0F, 8'hB4, 8'hEE};

    repeat (2) @(negedge clk);
    check("rst_valid", task_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_issued", issued_count, 16'd0);
    check("rst_dur", task_duration, 8'd0);
    reset_n = 1'b1;
    task_ready = 1'b1;
    @(negedge clk);

    // Single-task runs: LOAD, ISSUE, then DONE with one transfer.
    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].seed, vecs[i].mask, 16'd1, 8'd0);
      check($sformatf("v%0d_load_valid", i), task_valid, 1'b0);
      check($sformatf("v%0d_load_busy", i), busy, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), task_valid, 1'b1);
      check($sformatf("v%0d_prio", i), task_priority, vecs[i].prio);
      check($sformatf("v%0d_dur", i), task_duration, vecs[i].dur);
      @(negedge clk);
      check($sformatf("v%0d_done", i), done, 1'b1);
      check($sformatf("v%0d_issued", i), issued_count, 16'd1);
      check($sformatf("v%0d_valid_off", i), task_valid, 1'b0);
    end

    // Back-to-back stream of 8.
    start_run(16'hACE1, 8'hFF, 16'd8, 8'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("s%0d_valid", i), task_valid, 1'b1);
      check($sformatf("s%0d_prio", i), task_priority, s_prio[i]);
      check($sformatf("s%0d_dur", i), task_duration, s_dur[i]);
      check($sformatf("s%0d_issued", i), issued_count, i);
    end
    @(negedge clk);
    check("stream_done", done, 1'b1);
    check("stream_issued", issued_count, 16'd8);
    check("stream_busy", busy, 1'b0);
`ifdef TASK_GEN_PRIO_HIST_EN
    check("hist_p0", prio_hist[15:0], 16'd3);
    check("hist_p1", prio_hist[31:16], 16'd2);
    check("hist_p2", prio_hist[47:32], 16'd1);
    check("hist_p3", prio_hist[63:48], 16'd2);
`endif

    // Gap of 3: valid one cycle in four, done after the 4th transfer.
    start_run(16'hACE1, 8'hFF, 16'd4, 8'd3);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check($sformatf("g%0d_valid", c), task_valid, (c % 4) == 0);
      if (c % 4 == 0) check($sformatf("g%0d_dur", c), task_duration, s_dur[c/4]);
    end
    @(negedge clk);
    check("gap_done", done, 1'b1);
    check("gap_issued", issued_count, 16'd4);

    // Stall 5 cycles with stop raised mid-stall: payload holds, one transfer, then DONE.
    task_ready = 1'b0;
    start_run(16'hACE1, 8'hFF, 16'd0, 8'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("st%0d_valid", c), task_valid, 1'b1);
      check($sformatf("st%0d_prio", c), task_priority, 3'd1);
      check($sformatf("st%0d_dur", c), task_duration, 8'hAD);
      if (c == 2) stop = 1'b1;
    end
    task_ready = 1'b1;
    @(negedge clk);
    check("stop_done", done, 1'b1);
    check("stop_issued", issued_count, 16'd1);
    check("stop_valid", task_valid, 1'b0);
    stop = 1'b0;

    // Asynchronous reset in the middle of a GAP.
    start_run(16'hACE1, 8'hFF, 16'd0, 8'd5);
    @(negedge clk);
    check("pre_gap_valid", task_valid, 1'b1);
    @(negedge clk);
    check("gap_state_valid", task_valid, 1'b0);
    check("gap_state_busy", busy, 1'b1);
    check("gap_state_issued", issued_count, 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", task_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_issued", issued_count, 16'd0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);

    // Recovery run after reset.
    start_run(16'h0000, 8'h00, 16'd1, 8'd0);
    @(negedge clk);
    check("rec_valid", task_valid, 1'b1);
    check("rec_dur", task_duration, 8'h01);
    @(negedge clk);
    check("rec_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
